sam_gen: RTL and testbench

SAM_GEN -- requirements
Module: sam_gen

---
 rtl/sam_pkg.sv | 29 ++
 rtl/sam_runlen.sv | 57 +++++
 rtl/sam_gen.sv | 174 +++++++++++++++++
 tb/tb_sam_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// Shared definitions for the sam_gen decryptor.
//   state_t   : top-level FSM states
//   rl_cmd_t  : command word from the FSM to the run-length counters
//   max_run() : saturation value for a CW-bit run counter (2^CW - 1)
package sam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_ONES,
    ST_ZEROS,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    RL_HOLD,
    RL_CLEAR,
    RL_START_ONE,
    RL_INC_ONE,
    RL_START_ZERO,
    RL_INC_ZERO
  } rl_cmd_t;

  function automatic int max_run(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/sam_runlen.sv
// Run-length measurement for one symbol: a ones counter and a zeros
// counter, both saturating at MAXRUN, plus the comparisons the FSM needs.
//   clk, reset : clock, asynchronous active-low reset
//   cmd        : counter operation for this cycle
//   near_max   : zeros is one below MAXRUN (next zero closes the symbol)
//   raw        : ones > zeros (current counts)
//   tie        : ones == zeros (current counts)
//   tie_max    : ones == MAXRUN (tie against a saturated zeros run)
module sam_runlen
  import sam_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic    clk,
  input  logic    reset,
  input  rl_cmd_t cmd,
  output logic    near_max,
  output logic    raw,
  output logic    tie,
  output logic    tie_max
);

  localparam logic [CW-1:0] MAXRUN = CW'(max_run(CW));

  logic [CW-1:0] ones;
  logic [CW-1:0] zeros;

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones  <= '0;
      zeros <= '0;
    end else begin
      case (cmd)
        RL_CLEAR: begin
          ones  <= '0;
          zeros <= '0;
        end
        RL_START_ONE: begin
          ones  <= CW'(1);
          zeros <= '0;
        end
        RL_INC_ONE:    if (ones != MAXRUN) ones <= ones + 1'b1;
        RL_START_ZERO: zeros <= CW'(1);
        RL_INC_ZERO:   if (zeros != MAXRUN) zeros <= zeros + 1'b1;
        default: ;
      endcase
    end
  end

  assign near_max = (zeros == MAXRUN - 1'b1);
  assign raw      = (ones > zeros);
  assign tie      = (ones == zeros);
  assign tie_max  = (ones == MAXRUN);

endmodule

// File: rtl/sam_gen.sv
// Serial run-length decryptor. A header {n, d, capsN} is shifted in MSB
// first while mode=1; afterwards each symbol (a run of ones followed by a
// run of zeros) yields raw = ones > zeros, decrypted with keystream
// K = d ^ capsN walked from bit KW-1 downwards.
//   clk, reset : clock, asynchronous active-low reset
//   str        : serial header / message stream
//   mode       : 1 = header load (aborts anything in progress), 0 = message
//   msg        : decrypted bit, holds between frames
//   frame      : one-cycle strobe qualifying msg
//   err        : one-cycle strobe with frame when ones == zeros
//   done       : level, n symbols emitted, cleared by the next header load
module sam_gen
  import sam_pkg::*;
#(
  parameter int NW = 4,
  parameter int KW = 8,
  parameter int CW = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic str,
  input  logic mode,
  output logic msg,
  output logic frame,
  output logic err,
  output logic done
);

  localparam int HW  = NW + 2 * KW;
  localparam int HCW = $clog2(HW + 1);
  localparam int KIW = $clog2(KW);

  state_t          state, state_n;
  logic [HW-1:0]   hdr;
  logic [HCW-1:0]  hdr_cnt, hdr_base;
  logic [KW-1:0]   key;
  logic [NW-1:0]   sym_cnt, sym_inc;
  logic [KIW-1:0]  kidx;

  logic [NW-1:0]   n;
  logic [KW-1:0]   d, caps_n;

  rl_cmd_t rl_cmd;
  logic    near_max, rl_raw, rl_tie, rl_tie_max;
  logic    emit, raw_sel, tie_sel, start_msg, to_done, last_sym;

  assign n       = hdr[HW-1 -: NW];
  assign d       = hdr[2*KW-1 -: KW];
  assign caps_n  = hdr[KW-1:0];
  assign sym_inc = sym_cnt + 1'b1;
  assign last_sym = (sym_inc == n);

  // Entering LOAD from any other state restarts the header; the first
  // mode=1 cycle already captures header bit 0.
  assign hdr_base = (state == ST_LOAD) ? hdr_cnt : '0;

  sam_runlen #(.CW(CW)) u_runlen (
    .clk      (clk),
    .reset    (reset),
    .cmd      (rl_cmd),
    .near_max (near_max),
    .raw      (rl_raw),
    .tie      (rl_tie),
    .tie_max  (rl_tie_max)
  );

  // NOTE: every output of this block is defaulted first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    rl_cmd    = RL_HOLD;
    emit      = 1'b0;
    raw_sel   = rl_raw;
    tie_sel   = rl_tie;
    start_msg = 1'b0;
    to_done   = 1'b0;
    if (mode) begin
      state_n = ST_LOAD;
      rl_cmd  = RL_CLEAR;
    end else begin
      case (state)
        ST_LOAD: begin
          if (hdr_cnt == HCW'(HW)) begin
            state_n   = ST_SYNC;
            start_msg = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_SYNC: begin
          if (n == '0) begin
            state_n = ST_DONE;
            to_done = 1'b1;
          end else if (str) begin
            state_n = ST_ONES;
            rl_cmd  = RL_START_ONE;
          end
        end
        ST_ONES: begin
          if (str) begin
            rl_cmd = RL_INC_ONE;
          end else begin
            state_n = ST_ZEROS;
            rl_cmd  = RL_START_ZERO;
          end
        end
        ST_ZEROS: begin
          if (str) begin
            // The closing 1 is also the first 1 of the next symbol.
            emit    = 1'b1;
            state_n = ST_ONES;
            rl_cmd  = RL_START_ONE;
          end else begin
            rl_cmd = RL_INC_ZERO;
            if (near_max) begin
              // Zeros saturate at MAXRUN, which ones can never exceed.
              emit    = 1'b1;
              raw_sel = 1'b0;
              tie_sel = rl_tie_max;
              state_n = ST_SYNC;
            end
          end
        end
        default: ;
      endcase
      if (emit && last_sym) begin
        state_n = ST_DONE;
        to_done = 1'b1;
      end
    end
  end

  // NOTE: all control and datapath registers are reset so every output is
  // defined immediately after reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      hdr     <= '0;
      hdr_cnt <= '0;
      key     <= '0;
      sym_cnt <= '0;
      kidx    <= '0;
      msg     <= 1'b0;
      frame   <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      frame <= emit;
      err   <= emit & tie_sel;
      if (emit) begin
        msg     <= raw_sel ^ key[kidx];
        sym_cnt <= sym_inc;
        kidx    <= (kidx == '0) ? KIW'(KW - 1) : kidx - 1'b1;
      end
      if (mode) begin
        if (hdr_base < HCW'(HW)) begin
          hdr     <= {hdr[HW-2:0], str};
          hdr_cnt <= hdr_base + 1'b1;
        end else begin
          hdr_cnt <= hdr_base;
        end
      end
      if (start_msg) begin
        key     <= d ^ caps_n;
        sym_cnt <= '0;
        kidx    <= KIW'(KW - 1);
      end
      if (mode)         done <= 1'b0;
      else if (to_done) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sam_gen.sv
// Directed bench for sam_gen (NW=4, KW=8, CW=5). Inputs change 1 time unit
// after each rising edge; outputs are sampled at the same point.
module tb_sam_gen;
  import sam_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic str = 1'b0;
  logic mode = 1'b0;
  logic msg, frame, err, done;

  int tests_run = 0;
  int tests_failed = 0;
  logic [1:0] fq[$];  // observed frames as {err, msg}

  always #5 clk = ~clk;

  sam_gen #(.NW(4), .KW(8), .CW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .str   (str),
    .mode  (mode),
    .msg   (msg),
    .frame (frame),
    .err   (err),
    .done  (done)
  );

  task automatic tick(input logic s, input logic m);
    str  = s;
    mode = m;
    @(posedge clk);
    #1;
    if (frame === 1'b1) fq.push_back({err, msg});
  endtask

  task automatic load_header(input logic [3:0] hn, input logic [7:0] hd, input logic [7:0] hc);
    logic [19:0] h;
    h = {hn, hd, hc};
    for (int i = 19; i >= 0; i--) tick(h[i], 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic symbol(input int a, input int b);
    for (int i = 0; i < a; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < b; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({msg, frame, err, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0000", {msg, frame, err, done});
    end
    tests_run++;
    if (dut.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [1:0] exp_q[$];
    exp_q = '{2'b00, 2'b00, 2'b11};
    fq.delete();
    load_header(4'd3, 8'hA5, 8'h00);
    symbol(10, 6);
    symbol(7, 12);
    symbol(9, 9);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_early: got %b want 0", done);
    end
    tick(1'b1, 1'b0);
    symbol(3, 2);        // DONE ignores the stream
    tick(1'b1, 1'b0);
    tests_run++;
    if (fq.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d want %0d", fq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < fq.size(); i++) begin
      tests_run++;
      if (fq[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL basic_frame%0d: got {err,msg}=%b want %b", i, fq[i], exp_q[i]);
      end
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done: got %b want 1", done);
    end
  endtask

  task automatic test_keys();
    logic [1:0] exp_q[$];
    exp_q = '{2'b00, 2'b01};
    fq.delete();
    load_header(4'd2, 8'h00, 8'hFF);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL keys_done_cleared: got %b want 0", done);
    end
    symbol(20, 5);
    symbol(5, 20);
    tick(1'b1, 1'b0);
    tests_run++;
    if (fq.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL keys_count: got %0d want %0d", fq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < fq.size(); i++) begin
      tests_run++;
      if (fq[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL keys_frame%0d: got {err,msg}=%b want %b", i, fq[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    // 40 ones saturate at 31: (40,3) -> 1^K[7]=0; (40,10) -> 1^K[6]=1.
    logic [1:0] exp_q[$];
    exp_q = '{2'b00, 2'b01};
    fq.delete();
    load_header(4'd2, 8'hA5, 8'h00);
    symbol(40, 3);
    symbol(40, 10);
    tick(1'b1, 1'b0);
    tests_run++;
    if (fq.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL sat_count: got %0d want %0d", fq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < fq.size(); i++) begin
      tests_run++;
      if (fq[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL sat_frame%0d: got {err,msg}=%b want %b", i, fq[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    load_header(4'd2, 8'hA5, 8'h00);
    fq.delete();
    symbol(5, 30);
    tests_run++;
    if (frame !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_early: got frame=%b want 0", frame);
    end
    tick(1'b0, 1'b0);    // 31st zero closes the symbol
    tests_run++;
    if ({frame, err, msg} !== 3'b101) begin
      tests_failed++;
      $display("FAIL timeout_frame: got {frame,err,msg}=%b want 101", {frame, err, msg});
    end
    tests_run++;
    if (dut.state !== ST_SYNC) begin
      tests_failed++;
      $display("FAIL timeout_state: got %0d want %0d", dut.state, ST_SYNC);
    end
    symbol(0, 10);       // SYNC ignores zeros
    symbol(3, 2);
    tick(1'b1, 1'b0);
    tests_run++;
    if (fq.size() != 2) begin
      tests_failed++;
      $display("FAIL timeout_count: got %0d want 2", fq.size());
    end else begin
      tests_run++;
      if (fq[1] !== 2'b01) begin
        tests_failed++;
        $display("FAIL timeout_next: got {err,msg}=%b want 01", fq[1]);
      end
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_done: got %b want 1", done);
    end
  endtask

  task automatic test_n_zero();
    load_header(4'd0, 8'hA5, 8'h00);
    fq.delete();
    tick(1'b0, 1'b0);
    symbol(3, 2);
    tick(1'b1, 1'b0);
    tests_run++;
    if (fq.size() != 0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL n_zero: got frames=%0d done=%b want frames=0 done=1", fq.size(), done);
    end
  endtask

  task automatic test_abort();
    load_header(4'd3, 8'hA5, 8'h00);
    fq.delete();
    symbol(4, 0);
    for (int i = 0; i < 5; i++) tick(i[0], 1'b1);
    tick(1'b0, 1'b0);
    tests_run++;
    if (dut.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL abort_state: got %0d want %0d", dut.state, ST_IDLE);
    end
    symbol(3, 2);
    symbol(3, 2);
    tick(1'b1, 1'b0);
    tests_run++;
    if (fq.size() != 0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got frames=%0d done=%b want frames=0 done=0", fq.size(), done);
    end
  endtask

  task automatic test_async_reset();
    load_header(4'd2, 8'h00, 8'h00);
    symbol(3, 2);
    tick(1'b1, 1'b0);    // closes symbol 0, now in ONES with frame high
    tests_run++;
    if ({frame, msg} !== 2'b11) begin
      tests_failed++;
      $display("FAIL areset_pre: got {frame,msg}=%b want 11", {frame, msg});
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({msg, frame, err, done} !== 4'b0000 || dut.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL areset_async: got outputs=%b state=%0d want 0000 state=%0d",
               {msg, frame, err, done}, dut.state, ST_IDLE);
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_wrap();
    // K=8'h80, every raw=1: k=7 gives 0, k=6..0 give 1, the 9th wraps to k=7.
    logic [1:0] exp_q[$];
    exp_q = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    fq.delete();
    load_header(4'd9, 8'h80, 8'h00);
    for (int i = 0; i < 9; i++) symbol(3, 2);
    tick(1'b1, 1'b0);
    tests_run++;
    if (fq.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d want %0d", fq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < fq.size(); i++) begin
      tests_run++;
      if (fq[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL wrap_frame%0d: got {err,msg}=%b want %b", i, fq[i], exp_q[i]);
      end
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_done: got %b want 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_keys();
    test_saturation();
    test_timeout();
    test_n_zero();
    test_abort();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
